// File: rtl/switch_selftest_seq_pkg.sv
// Shared definitions for the switch self-test sequencer.
// Holds the FSM state encoding, the step-table entry layout, the switch-app
// register addresses and small helpers used by the sequencer and its ROM.
package switch_selftest_seq_pkg;

    localparam int unsigned STEP_W   = 4;
    localparam int unsigned SETTLE_W = 13;
    localparam int unsigned TMO_W    = 5;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned FIELD_W  = 12;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_READ    = 3'd3,
        ST_WAIT_RD = 3'd4,
        ST_CHECK   = 3'd5,
        ST_NEXT    = 3'd6,
        ST_FINISH  = 3'd7
    } state_t;

    // One step of the self-test table
    typedef struct packed {
        logic [ADDR_W-1:0]  wr_addr;
        logic [ADDR_W-1:0]  rd_addr;
        logic [FIELD_W-1:0] wdata;
        logic [FIELD_W-1:0] expected;
        logic [FIELD_W-1:0] mask;
        logic               long_settle;
    } step_entry_t;

    // Switch-app register addresses on the common address bus
    localparam logic [ADDR_W-1:0] WRITE_LOOPBACK_MUX       = 8'h20;
    localparam logic [ADDR_W-1:0] WRITE_SELF_TEST_SWITCHES = 8'h21;
    localparam logic [ADDR_W-1:0] WRITE_IO_PIN_SWITCHES    = 8'h22;
    localparam logic [ADDR_W-1:0] WRITE_INTEGRATOR         = 8'h23;
    localparam logic [ADDR_W-1:0] WRITE_ANLG_IN_B1         = 8'h24;
    localparam logic [ADDR_W-1:0] READ_LOOPBACK_MUX        = 8'hA0;
    localparam logic [ADDR_W-1:0] READ_SELF_TEST_SWITCHES  = 8'hA1;
    localparam logic [ADDR_W-1:0] READ_IO_PIN_SWITCHES     = 8'hA2;
    localparam logic [ADDR_W-1:0] READ_INTEGRATOR          = 8'hA3;
    localparam logic [ADDR_W-1:0] READ_ANLG_IN_B1          = 8'hA4;

    // Build a table entry from its fields
    function automatic step_entry_t make_entry(
        input logic [ADDR_W-1:0]  wa,
        input logic [ADDR_W-1:0]  ra,
        input logic [FIELD_W-1:0] wd,
        input logic [FIELD_W-1:0] ex,
        input logic [FIELD_W-1:0] mk,
        input logic               lg
    );
        step_entry_t e;
        e.wr_addr     = wa;
        e.rd_addr     = ra;
        e.wdata       = wd;
        e.expected    = ex;
        e.mask        = mk;
        e.long_settle = lg;
        return e;
    endfunction

    // Masked compare of a readback word against the entry's expected value
    function automatic logic step_match(
        input logic [DATA_W-1:0] captured,
        input step_entry_t       e
    );
        logic [DATA_W-1:0] mask16;
        mask16 = {4'h0, e.mask};
        return (captured & mask16) == ({4'h0, e.expected} & mask16);
    endfunction

endpackage

// File: rtl/switch_selftest_rom.sv
// Default self-test step table, combinational step -> entry lookup.
// Ports:
//   step  - table index
//   entry - write/read addresses, write data, expected value, mask, settle flag
// Indices past the populated table return an all-zero entry.
module switch_selftest_rom
    import switch_selftest_seq_pkg::*;
(
    input  logic [STEP_W-1:0] step,
    output step_entry_t       entry
);

    // Final two entries return the switches to their open state
    always_comb begin
        entry = '0;
        case (step)
            4'd0: entry = make_entry(WRITE_LOOPBACK_MUX, READ_LOOPBACK_MUX,
                                     12'h009, 12'h009, 12'h00F, 1'b0);
            4'd1: entry = make_entry(WRITE_SELF_TEST_SWITCHES, READ_SELF_TEST_SWITCHES,
                                     12'h0A5, 12'h0A5, 12'h0FF, 1'b0);
            4'd2: entry = make_entry(WRITE_IO_PIN_SWITCHES, READ_IO_PIN_SWITCHES,
                                     12'h5A3, 12'h5A3, 12'hFFF, 1'b0);
            4'd3: entry = make_entry(WRITE_INTEGRATOR, READ_INTEGRATOR,
                                     12'h001, 12'h001, 12'h001, 1'b0);
            // Only the lowest set B1 switch drives, so 0x3 reads back as 0x1
            4'd4: entry = make_entry(WRITE_ANLG_IN_B1, READ_ANLG_IN_B1,
                                     12'h003, 12'h001, 12'h00F, 1'b1);
            4'd5: entry = make_entry(WRITE_ANLG_IN_B1, READ_ANLG_IN_B1,
                                     12'h000, 12'h000, 12'h00F, 1'b1);
            4'd6: entry = make_entry(WRITE_LOOPBACK_MUX, READ_LOOPBACK_MUX,
                                     12'h000, 12'h000, 12'h00F, 1'b0);
            4'd7: entry = make_entry(WRITE_SELF_TEST_SWITCHES, READ_SELF_TEST_SWITCHES,
                                     12'h000, 12'h000, 12'h0FF, 1'b0);
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/switch_selftest_seq.sv
// Board self-test bus initiator for the analog-switch application.
// On start, walks the step table: write a switch register, settle, read it
// back, compare under mask; reports pass or the first failing step.
// Ports:
//   xclk, reset              - clock, async active-low reset
//   start, abort             - one-cycle request / level abort
//   m_ab, m_db               - address / write data to the switch app
//   m_write_qualified        - one-cycle write strobe
//   m_read_qualified         - one-cycle read strobe
//   s_db_in, s_data_avail    - readback data / data-available from the app
//   busy, done               - sequence active / one-cycle completion pulse
//   pass, fail_step, fail_data - result of the last sequence
module switch_selftest_seq
    import switch_selftest_seq_pkg::*;
#(
    parameter int unsigned NUM_STEPS    = 8,
    parameter int unsigned SHORT_SETTLE = 4,
    parameter int unsigned LONG_SETTLE  = 3750,
    parameter int unsigned RD_TIMEOUT   = 16
) (
    input  logic        xclk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [7:0]  m_ab,
    output logic [15:0] m_db,
    output logic        m_write_qualified,
    output logic        m_read_qualified,
    input  logic [15:0] s_db_in,
    input  logic        s_data_avail,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_step,
    output logic [15:0] fail_data
);

    // Settle counter counts down to 0, so it is loaded one short of the span
    localparam logic [SETTLE_W-1:0] SHORT_LOAD = SETTLE_W'(SHORT_SETTLE - 32'd1);
    localparam logic [SETTLE_W-1:0] LONG_LOAD  = SETTLE_W'(LONG_SETTLE - 32'd1);
    localparam logic [TMO_W-1:0]    TMO_LOAD   = TMO_W'(RD_TIMEOUT);
    localparam logic [STEP_W-1:0]   LAST_STEP  = STEP_W'(NUM_STEPS - 32'd1);
    localparam logic [3:0]          NO_STEP    = 4'hF;
    localparam logic [15:0]         TMO_DATA   = 16'hDEAD;

    state_t              state, state_nx;
    logic [STEP_W-1:0]   step, step_nx, rom_idx;
    logic [SETTLE_W-1:0] settle_cnt, settle_nx;
    logic [TMO_W-1:0]    tmo_cnt, tmo_nx;
    logic [DATA_W-1:0]   captured, captured_nx;
    step_entry_t         entry;

    logic                pass_nx;
    logic [3:0]          fail_step_nx;
    logic [15:0]         fail_data_nx;
    logic [7:0]          m_ab_nx;
    logic [15:0]         m_db_nx;
    logic                wr_nx, rd_nx, busy_nx, done_nx;

    // ROM index looks ahead to the step whose strobe is about to be issued
    always_comb begin
        rom_idx = step;
        if (state == ST_IDLE) begin
            rom_idx = '0;
        end else if (state == ST_NEXT) begin
            rom_idx = step + STEP_W'(1);
        end
    end

    switch_selftest_rom u_rom (
        .step  (rom_idx),
        .entry (entry)
    );

    // State and output registers
    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            state             <= ST_IDLE;
            step              <= '0;
            settle_cnt        <= '0;
            tmo_cnt           <= '0;
            captured          <= '0;
            m_ab              <= '0;
            m_db              <= '0;
            m_write_qualified <= 1'b0;
            m_read_qualified  <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            pass              <= 1'b0;
            fail_step         <= NO_STEP;
            fail_data         <= '0;
        end else begin
            state             <= state_nx;
            step              <= step_nx;
            settle_cnt        <= settle_nx;
            tmo_cnt           <= tmo_nx;
            captured          <= captured_nx;
            m_ab              <= m_ab_nx;
            m_db              <= m_db_nx;
            m_write_qualified <= wr_nx;
            m_read_qualified  <= rd_nx;
            busy              <= busy_nx;
            done              <= done_nx;
            pass              <= pass_nx;
            fail_step         <= fail_step_nx;
            fail_data         <= fail_data_nx;
        end
    end

    // Next-state, counters and result bookkeeping
    always_comb begin
        state_nx     = state;
        step_nx      = step;
        settle_nx    = settle_cnt;
        tmo_nx       = tmo_cnt;
        captured_nx  = captured;
        pass_nx      = pass;
        fail_step_nx = fail_step;
        fail_data_nx = fail_data;

        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nx     = ST_WRITE;
                    step_nx      = '0;
                    pass_nx      = 1'b0;
                    fail_step_nx = NO_STEP;
                    fail_data_nx = '0;
                end
            end
            ST_WRITE: begin
                settle_nx = entry.long_settle ? LONG_LOAD : SHORT_LOAD;
                state_nx  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nx = ST_READ;
                end else begin
                    settle_nx = settle_cnt - SETTLE_W'(1);
                end
            end
            ST_READ: begin
                tmo_nx   = TMO_LOAD;
                state_nx = ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                // Counter still at its load value marks the first cycle, where
                // data-available may be left over from the previous read
                if ((tmo_cnt != TMO_LOAD) && s_data_avail) begin
                    captured_nx = s_db_in;
                    state_nx    = ST_CHECK;
                end else if (tmo_cnt == '0) begin
                    fail_step_nx = step;
                    fail_data_nx = TMO_DATA;
                    state_nx     = ST_FINISH;
                end else begin
                    tmo_nx = tmo_cnt - TMO_W'(1);
                end
            end
            ST_CHECK: begin
                if (step_match(captured, entry)) begin
                    state_nx = ST_NEXT;
                end else begin
                    fail_step_nx = step;
                    fail_data_nx = captured;
                    state_nx     = ST_FINISH;
                end
            end
            ST_NEXT: begin
                if (step == LAST_STEP) begin
                    pass_nx  = 1'b1;
                    state_nx = ST_FINISH;
                end else begin
                    step_nx  = step + STEP_W'(1);
                    state_nx = ST_WRITE;
                end
            end
            ST_FINISH: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Abort overrides everything once the sequence is running; FINISH is
        // left alone so it cannot produce a second done pulse
        if (abort && (state != ST_IDLE) && (state != ST_FINISH)) begin
            state_nx     = ST_FINISH;
            pass_nx      = 1'b0;
            fail_step_nx = NO_STEP;
            fail_data_nx = fail_data;
        end
    end

    // Registered bus and status outputs follow the state being entered
    always_comb begin
        wr_nx   = (state_nx == ST_WRITE);
        rd_nx   = (state_nx == ST_READ);
        busy_nx = (state_nx != ST_IDLE);
        done_nx = (state_nx == ST_FINISH);
        m_ab_nx = '0;
        m_db_nx = '0;
        if (wr_nx) begin
            m_ab_nx = entry.wr_addr;
            m_db_nx = {4'h0, entry.wdata};
        end else if (rd_nx) begin
            m_ab_nx = entry.rd_addr;
        end
    end

endmodule

// File: tb/tb_switch_selftest_seq.sv
// Self-checking bench for switch_selftest_seq with a behavioural switch app.
`timescale 1ns/1ps
module tb_switch_selftest_seq;
    import switch_selftest_seq_pkg::*;

    localparam int NS    = 8;
    localparam int SHORT = 4;
    localparam int LONG  = 10;
    localparam int TMO   = 16;
    localparam int MAXC  = 256;

    logic        xclk   = 1'b0;
    logic        reset  = 1'b0;
    logic        start  = 1'b0;
    logic        abort  = 1'b0;
    logic [7:0]  m_ab;
    logic [15:0] m_db;
    logic        m_write_qualified, m_read_qualified;
    logic [15:0] s_db_in;
    logic        s_data_avail;
    logic        busy, done, pass;
    logic [3:0]  fail_step;
    logic [15:0] fail_data;

    int n_tests = 0;
    int n_fail  = 0;

    switch_selftest_seq #(
        .NUM_STEPS    (NS),
        .SHORT_SETTLE (SHORT),
        .LONG_SETTLE  (LONG),
        .RD_TIMEOUT   (TMO)
    ) dut (
        .xclk              (xclk),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .m_ab              (m_ab),
        .m_db              (m_db),
        .m_write_qualified (m_write_qualified),
        .m_read_qualified  (m_read_qualified),
        .s_db_in           (s_db_in),
        .s_data_avail      (s_data_avail),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .fail_step         (fail_step),
        .fail_data         (fail_data)
    );

    always #13 xclk = ~xclk;

    int cycle_no = 0;
    always @(posedge xclk) cycle_no <= cycle_no + 1;

    // ---------------- behavioural switch app ----------------
    // mode 0 normal, 1 loopback reads 0x8, 2 IO-pin read never ready,
    // 3 data lands one cycle late while avail stays high
    int          app_mode = 0;
    logic [11:0] app_reg [0:7];
    logic [15:0] pend_d;
    logic        pend_v;

    function automatic int wr_idx(input logic [7:0] a);
        case (a)
            WRITE_LOOPBACK_MUX:       return 0;
            WRITE_SELF_TEST_SWITCHES: return 1;
            WRITE_IO_PIN_SWITCHES:    return 2;
            WRITE_INTEGRATOR:         return 3;
            WRITE_ANLG_IN_B1:         return 4;
            default:                  return 7;
        endcase
    endfunction

    function automatic int rd_idx(input logic [7:0] a);
        case (a)
            READ_LOOPBACK_MUX:       return 0;
            READ_SELF_TEST_SWITCHES: return 1;
            READ_IO_PIN_SWITCHES:    return 2;
            READ_INTEGRATOR:         return 3;
            READ_ANLG_IN_B1:         return 4;
            default:                 return 7;
        endcase
    endfunction

    function automatic logic [15:0] app_value(input logic [7:0] a);
        logic [11:0] v;
        v = app_reg[rd_idx(a)];
        if (a == READ_ANLG_IN_B1) v = v & (~v + 12'd1);
        if (app_mode == 1 && a == READ_LOOPBACK_MUX) return 16'h0008;
        return {4'h0, v};
    endfunction

    always @(posedge xclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) app_reg[i] <= 12'h0;
            s_db_in      <= 16'h0;
            s_data_avail <= 1'b0;
            pend_d       <= 16'h0;
            pend_v       <= 1'b0;
        end else begin
            pend_v <= 1'b0;
            if (app_mode == 3 && !s_data_avail) begin
                s_data_avail <= 1'b1;
                s_db_in      <= 16'hFFFF;
            end
            if (m_write_qualified) app_reg[wr_idx(m_ab)] <= m_db[11:0];
            if (m_read_qualified) begin
                if (app_mode == 3) begin
                    pend_d <= app_value(m_ab);
                    pend_v <= 1'b1;
                end else if (app_mode == 2 && m_ab == READ_IO_PIN_SWITCHES) begin
                    s_data_avail <= 1'b0;
                end else begin
                    s_db_in      <= app_value(m_ab);
                    s_data_avail <= 1'b1;
                end
            end
            if (pend_v) s_db_in <= pend_d;
        end
    end

    // ---------------- expected-behaviour model ----------------
    logic [7:0]  t_wa [0:NS-1];
    logic [7:0]  t_ra [0:NS-1];
    logic [11:0] t_wd [0:NS-1];
    bit          t_long [0:NS-1];

    bit          e_wr [0:MAXC-1];
    bit          e_rd [0:MAXC-1];
    logic [7:0]  e_ab [0:MAXC-1];
    logic [15:0] e_db [0:MAXC-1];
    int          done_off;
    int          chk_end;
    logic        e_pass;
    logic [3:0]  e_fstep;
    logic [15:0] e_fdata;

    task automatic clear_plan();
        for (int c = 0; c < MAXC; c++) begin
            e_wr[c] = 0; e_rd[c] = 0; e_ab[c] = 8'h0; e_db[c] = 16'h0;
        end
        done_off = -1; e_pass = 0; e_fstep = 4'hF; e_fdata = 16'h0;
        chk_end  = 8;
    endtask

    // Per-cycle strobe schedule relative to the start cycle (offset 0)
    task automatic build_plan(input int abort_at, input int tmo_step,
                              input int bad_step, input logic [15:0] bad_val);
        int t, n, r;
        clear_plan();
        t = 1;
        for (int k = 0; k < NS; k++) begin
            n = t_long[k] ? LONG : SHORT;
            e_wr[t] = 1; e_ab[t] = t_wa[k]; e_db[t] = {4'h0, t_wd[k]};
            r = t + n + 1;
            e_rd[r] = 1; e_ab[r] = t_ra[k];
            if (k == tmo_step) begin
                done_off = r + 2 + TMO; e_fstep = 4'(k); e_fdata = 16'hDEAD;
                break;
            end
            if (k == bad_step) begin
                done_off = t + n + 5; e_fstep = 4'(k); e_fdata = bad_val;
                break;
            end
            if (k == NS - 1) begin
                done_off = t + n + 6; e_pass = 1;
            end
            t = t + n + 6;
        end
        if (abort_at > 0 && abort_at < done_off) begin
            for (int c = abort_at + 1; c < MAXC; c++) begin
                e_wr[c] = 0; e_rd[c] = 0; e_ab[c] = 8'h0; e_db[c] = 16'h0;
            end
            done_off = abort_at + 1; e_pass = 0; e_fstep = 4'hF; e_fdata = 16'h0;
        end
        chk_end = done_off + 4;
    endtask

    // ---------------- per-cycle compare ----------------
    bit          chk_on = 0;
    int          start_cycle = 0;
    int          cmp_off;
    logic [27:0] exp_bus, act_bus;
    logic [20:0] exp_res, act_res;

    always @(negedge xclk) begin
        if (chk_on) begin
            cmp_off = cycle_no - start_cycle;
            if (cmp_off >= 0 && cmp_off <= chk_end && cmp_off < MAXC) begin
                exp_bus = {e_wr[cmp_off], e_rd[cmp_off], e_ab[cmp_off], e_db[cmp_off],
                           (cmp_off >= 1 && cmp_off <= done_off), (cmp_off == done_off)};
                act_bus = {m_write_qualified, m_read_qualified, m_ab, m_db, busy, done};
                n_tests++;
                if (act_bus !== exp_bus) begin
                    n_fail++;
                    $display("FAIL bus off=%0d got {wr,rd,ab,db,busy,done}=%h want %h",
                             cmp_off, act_bus, exp_bus);
                end
                if (cmp_off == done_off) begin
                    exp_res = {e_pass, e_fstep, e_fdata};
                    act_res = {pass, fail_step, fail_data};
                    n_tests++;
                    if (act_res !== exp_res) begin
                        n_fail++;
                        $display("FAIL result off=%0d got {pass,step,data}=%h want %h",
                                 cmp_off, act_res, exp_res);
                    end
                end
            end
        end
    end

    // First readback of the B1 register as seen on the app's data bus
    bit          rd_anlg_q = 0;
    bit          anlg_got  = 0;
    logic [15:0] anlg_seen = 16'h0;
    always @(negedge xclk) begin
        if (rd_anlg_q && !anlg_got) begin
            anlg_seen = s_db_in;
            anlg_got  = 1;
        end
        rd_anlg_q = m_read_qualified && (m_ab == READ_ANLG_IN_B1);
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_rst(input string name);
        check_val(name, {m_write_qualified, m_read_qualified, busy, done, pass, fail_step,
                         m_ab, m_db[11:0]}, {5'b0, 4'hF, 8'h0, 12'h0});
        check_val({name, "_hi"}, {m_db[15:12], fail_data}, 20'h0);
    endtask

    // Start pulse in offset 0; optional abort / extra start at given offsets
    task automatic run_seq(input int abort_at, input int busy_start_at);
        @(posedge xclk); #1;
        start = 1; start_cycle = cycle_no; chk_on = 1;
        @(posedge xclk); #1;
        start = 0;
        while (cycle_no - start_cycle <= chk_end) begin
            abort = (cycle_no - start_cycle == abort_at);
            start = (cycle_no - start_cycle == busy_start_at);
            @(posedge xclk); #1;
        end
        chk_on = 0; abort = 0; start = 0;
    endtask

    initial begin
        t_wa   = '{WRITE_LOOPBACK_MUX, WRITE_SELF_TEST_SWITCHES, WRITE_IO_PIN_SWITCHES,
                   WRITE_INTEGRATOR, WRITE_ANLG_IN_B1, WRITE_ANLG_IN_B1,
                   WRITE_LOOPBACK_MUX, WRITE_SELF_TEST_SWITCHES};
        t_ra   = '{READ_LOOPBACK_MUX, READ_SELF_TEST_SWITCHES, READ_IO_PIN_SWITCHES,
                   READ_INTEGRATOR, READ_ANLG_IN_B1, READ_ANLG_IN_B1,
                   READ_LOOPBACK_MUX, READ_SELF_TEST_SWITCHES};
        t_wd   = '{12'h009, 12'h0A5, 12'h5A3, 12'h001, 12'h003, 12'h000, 12'h000, 12'h000};
        t_long = '{0, 0, 0, 0, 1, 1, 0, 0};
        clear_plan();

        // reset values
        reset = 0;
        repeat (3) @(posedge xclk);
        #1;
        check_rst("reset_vals");
        reset = 1;
        repeat (2) @(posedge xclk);
        #1;

        // full passing run
        app_mode = 0; anlg_got = 0;
        build_plan(-1, -1, -1, 16'h0);
        check_val("pass_done_off", 32'(done_off), 32'd93);
        run_seq(-1, -1);
        check_val("b1_readback", {15'h0, anlg_got, anlg_seen}, {15'h0, 1'b1, 16'h0001});
        check_val("pass_held", {pass, fail_step, fail_data}, {1'b1, 4'hF, 16'h0});

        // mismatch at step 0
        app_mode = 1;
        build_plan(-1, -1, 0, 16'h0008);
        check_val("bad_done_off", 32'(done_off), 32'd10);
        run_seq(-1, -1);
        check_val("bad_held", {pass, fail_step, fail_data}, {1'b0, 4'h0, 16'h0008});

        // read timeout at step 2
        app_mode = 2;
        build_plan(-1, 2, -1, 16'h0);
        check_val("tmo_done_off", 32'(done_off), 32'd44);
        run_seq(-1, -1);
        check_val("tmo_held", {pass, fail_step, fail_data}, {1'b0, 4'h2, 16'hDEAD});

        // stale data-available, fresh data one cycle late
        app_mode = 3;
        repeat (3) @(posedge xclk);
        #1;
        build_plan(-1, -1, -1, 16'h0);
        run_seq(-1, -1);

        // abort in step 4 settle, plus a start while busy
        app_mode = 0;
        build_plan(45, -1, -1, 16'h0);
        check_val("abort_done_off", 32'(done_off), 32'd46);
        run_seq(45, 30);

        // start and abort together in IDLE: nothing happens
        clear_plan();
        @(posedge xclk); #1;
        start = 1; abort = 1; start_cycle = cycle_no; chk_on = 1;
        @(posedge xclk); #1;
        start = 0; abort = 0;
        repeat (8) @(posedge xclk);
        #1;
        chk_on = 0;

        // reset asserted during step 0 read strobe
        @(posedge xclk); #1;
        start = 1; start_cycle = cycle_no;
        @(posedge xclk); #1;
        start = 0;
        repeat (5) @(posedge xclk);
        #1;
        check_val("rd_strobe_c6", {m_read_qualified, m_ab}, {1'b1, READ_LOOPBACK_MUX});
        reset = 0;
        #1;
        check_rst("reset_mid_read");
        repeat (3) begin
            @(negedge xclk);
            check_val("no_done_in_reset", {done, busy}, 2'b00);
        end
        @(posedge xclk); #1;
        reset = 1;
        repeat (3) begin
            @(negedge xclk);
            check_val("no_done_after_reset", {done, busy}, 2'b00);
        end
        build_plan(-1, -1, -1, 16'h0);
        run_seq(-1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
